// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and width helper for the universal shift register.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Saturating up-counter with clear and a registered pulse on reaching MAX.
module sat_counter
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned MAX = 8,
  localparam int unsigned W = cnt_w(MAX)
) (
  input  logic         clock,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         done
);

  localparam logic [W-1:0] MAX_V    = W'(MAX);
  localparam logic [W-1:0] MAX_M1_V = W'(MAX - 1);

  // done fires only on the MAX-1 -> MAX transition, so saturation cannot re-arm it
  always_ff @(posedge clock) begin
    if (!rstn) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt < MAX_V)) begin
        cnt  <= cnt + W'(1);
        done <= (cnt == MAX_M1_V);
      end
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, shift, rotate, load, clear, plus shift tracking.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned    CW          = cnt_w(WIDTH)
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  logic is_shift;
  logic is_reload;

  always_comb begin
    is_shift  = 1'b0;
    is_reload = 1'b0;
    if (en) begin
      is_shift  = (mode == MODE_SHL) || (mode == MODE_SHR) ||
                  (mode == MODE_ROL) || (mode == MODE_ROR);
      is_reload = (mode == MODE_LOAD) || (mode == MODE_CLEAR);
    end
  end

  // reserved encoding 3'b111 falls into the default hold
  always_ff @(posedge clock) begin
    if (!rstn) begin
      Q <= RESET_VALUE;
    end else if (en) begin
      case (mode)
        MODE_SHL:   Q <= {Q[WIDTH-2:0], sin_r};
        MODE_SHR:   Q <= {sin_l, Q[WIDTH-1:1]};
        MODE_ROL:   Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
        MODE_ROR:   Q <= {Q[0], Q[WIDTH-1:1]};
        MODE_LOAD:  Q <= d;
        MODE_CLEAR: Q <= RESET_VALUE;
        default:    Q <= Q;
      endcase
    end
  end

  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];

  sat_counter #(.MAX(WIDTH)) u_cnt (
    .clock (clock),
    .rstn  (rstn),
    .clr   (is_reload),
    .inc   (is_shift),
    .cnt   (shift_cnt),
    .done  (done)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed table, corner sequences and random vs. a reference model.
module tb_univ_shift_reg;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hA5;

  logic       clock = 1'b0;
  logic       rstn, en, sin_r, sin_l;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_l, sout_r, done;
  logic [3:0] shift_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0] m_q;
  int         m_cnt;
  logic       m_done;

  univ_shift_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clock(clock), .rstn(rstn), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .Q(q), .sout_l(sout_l), .sout_r(sout_r),
    .shift_cnt(shift_cnt), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sr;
    logic       sl;
    logic [7:0] eq;
    int         ec;
    logic       ed;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour at a rising edge, stated directly in word arithmetic.
  task automatic model_edge();
    bit moved = 0;
    if (!rstn) begin
      m_q = RV; m_cnt = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (!en) return;
    case (int'(mode))
      1: begin m_q = 8'((m_q * 2) + sin_r);              moved = 1; end
      2: begin m_q = 8'((m_q / 2) + (sin_l ? 128 : 0));  moved = 1; end
      3: begin m_q = 8'((m_q * 2) + (m_q / 128));        moved = 1; end
      4: begin m_q = 8'((m_q / 2) + (m_q % 2) * 128);    moved = 1; end
      5: begin m_q = d;  m_cnt = 0; end
      6: begin m_q = RV; m_cnt = 0; end
      default: ;
    endcase
    if (moved && m_cnt < W) begin
      m_cnt++;
      m_done = (m_cnt == W);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},      int'(q),         int'(m_q));
    check({tag, ".sout_l"}, int'(sout_l),    int'(m_q[7]));
    check({tag, ".sout_r"}, int'(sout_r),    int'(m_q[0]));
    check({tag, ".cnt"},    int'(shift_cnt), m_cnt);
    check({tag, ".done"},   int'(done),      int'(m_done));
  endtask

  // Called at a negedge: drive, cross one rising edge, sample at the next negedge.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] dd, input logic sr, input logic sl, input string tag);
    rstn = r; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
    @(posedge clock);
    @(negedge clock);
    model_edge();
    check_model(tag);
  endtask

  initial begin
    int pulses;
    int pulse_at;
    tbl[0]  = '{1, 3'b101, 8'hB4, 0, 0, 8'hB4, 0, 0};
    tbl[1]  = '{1, 3'b001, 8'h00, 0, 0, 8'h68, 1, 0};
    tbl[2]  = '{1, 3'b001, 8'h00, 0, 0, 8'hD0, 2, 0};
    tbl[3]  = '{1, 3'b001, 8'h00, 0, 0, 8'hA0, 3, 0};
    tbl[4]  = '{1, 3'b001, 8'h00, 0, 0, 8'h40, 4, 0};
    tbl[5]  = '{1, 3'b001, 8'h00, 0, 0, 8'h80, 5, 0};
    tbl[6]  = '{1, 3'b001, 8'h00, 0, 0, 8'h00, 6, 0};
    tbl[7]  = '{1, 3'b001, 8'h00, 0, 0, 8'h00, 7, 0};
    tbl[8]  = '{1, 3'b001, 8'h00, 0, 0, 8'h00, 8, 1};
    tbl[9]  = '{1, 3'b001, 8'h00, 0, 0, 8'h00, 8, 0};
    tbl[10] = '{1, 3'b101, 8'h81, 0, 0, 8'h81, 0, 0};
    tbl[11] = '{1, 3'b100, 8'h00, 0, 0, 8'hC0, 1, 0};
    tbl[12] = '{1, 3'b011, 8'h00, 0, 0, 8'h81, 2, 0};
    tbl[13] = '{1, 3'b011, 8'h00, 0, 0, 8'h03, 3, 0};
    tbl[14] = '{1, 3'b101, 8'h00, 0, 0, 8'h00, 0, 0};
    tbl[15] = '{1, 3'b010, 8'h00, 0, 1, 8'h80, 1, 0};
    tbl[16] = '{1, 3'b101, 8'h3C, 0, 0, 8'h3C, 0, 0};
    for (int i = 17; i < 22; i++) tbl[i] = '{0, 3'b001, 8'h00, 1, 1, 8'h3C, 0, 0};
    tbl[22] = '{1, 3'b000, 8'hFF, 1, 1, 8'h3C, 0, 0};
    tbl[23] = '{1, 3'b111, 8'hFF, 1, 1, 8'h3C, 0, 0};

    rstn = 1; en = 0; mode = 0; d = 0; sin_r = 0; sin_l = 0;
    m_q = 0; m_cnt = 0; m_done = 0;
    @(negedge clock);

    // reset overrides an enabled LOAD
    step(0, 1, 3'b101, 8'hFF, 0, 0, "reset");
    check("reset.q", int'(q), 8'hA5);
    check("reset.cnt", int'(shift_cnt), 0);
    check("reset.done", int'(done), 0);
    rstn = 1; en = 1; mode = 3'b101; d = 8'h11;
    #2;
    check("rstn_mid_cycle.q", int'(q), 8'hA5);
    @(negedge clock);
    m_q = 8'h11; m_cnt = 0; m_done = 0;
    check_model("load_after_reset");

    for (int i = 0; i < 24; i++) begin
      step(1, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sr, tbl[i].sl, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.q", i),    int'(q),         int'(tbl[i].eq));
      check($sformatf("tbl%0d.cnt", i),  int'(shift_cnt), tbl[i].ec);
      check($sformatf("tbl%0d.done", i), int'(done),      int'(tbl[i].ed));
    end

    // reset in the middle of a shift sequence: no done pulse afterwards
    step(1, 1, 3'b101, 8'hFF, 0, 0, "mid_load");
    for (int i = 0; i < 5; i++) step(1, 1, 3'b001, 0, 1, 0, "mid_shl");
    step(0, 1, 3'b001, 0, 1, 0, "mid_reset");
    check("mid_reset.q", int'(q), 8'hA5);
    check("mid_reset.cnt", int'(shift_cnt), 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 3'b001, 0, 0, 0, "post_reset_shl");
      if (done) pulses++;
    end
    check("mid_reset.no_done", pulses, 0);

    // CLEAR after 7 shifts, then 8 shifts: one pulse, on the 8th
    for (int i = 0; i < 7; i++) step(1, 1, 3'b011, 0, 0, 0, "pre_clear");
    step(1, 1, 3'b110, 8'h5A, 0, 0, "clear");
    check("clear.q", int'(q), 8'hA5);
    check("clear.cnt", int'(shift_cnt), 0);
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 3'((i % 4) + 1), 0, 1, 0, "post_clear");
      if (done) begin pulses++; pulse_at = i; end
    end
    check("clear.pulses", pulses, 1);
    check("clear.pulse_at", pulse_at, 8);

    // random traffic weighted toward shift modes
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rm;
      int sel = $urandom_range(0, 19);
      rm = (sel < 12) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0), rm,
           8'($urandom), 1'($urandom), 1'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
